alu_sequencer: RTL

Multi-cycle issue/writeback controller that drives the 16-bit LC-3b ALU. It accepts one operate instruction at a time: ADD, AND, XOR/NOT or SHF. It reads source registers from the register file, presents operands, op and shift amount to the ALU, and captures the result and flags. It then writes the destination register and updates the NZP condition codes, forming the operate-instruction datapath between fetch/decode and the register file.

---
 rtl/alu_sequencer_pkg.sv | 12 +
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_decode.sv | 36 +++
 rtl/alu_sequencer.sv | 96 +++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared opcodes, ALU op codes, FSM states and reset constants
package alu_sequencer_pkg;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_AND = 4'b0101;
    localparam logic [3:0] OPC_XOR = 4'b1001;
    localparam logic [3:0] OPC_SHF = 4'b1101;
    localparam logic [2:0] NZP_RST = 3'b010;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_AND, ALU_NOT, ALU_XOR, ALU_LSHF, ALU_RSHFL, ALU_RSHFA, ALU_ZERO
    } alu_op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, register file and ALU connections
interface alu_sequencer_if;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [15:0]                instr;
    logic [2:0]                 rf_raddr1;
    logic [2:0]                 rf_raddr2;
    logic [15:0]                rf_rdata1;
    logic [15:0]                rf_rdata2;
    logic                       rf_we;
    logic [2:0]                 rf_waddr;
    logic [15:0]                rf_wdata;
    logic [15:0]                alu_in1;
    logic [15:0]                alu_in2;
    alu_sequencer_pkg::alu_op_e alu_op;
    logic [3:0]                 alu_shift;
    logic [15:0]                alu_out;
    logic                       alu_zero;
    logic                       alu_positive;
    logic                       alu_negative;
    logic [2:0]                 nzp;
    logic                       done;
    logic                       illegal;
    modport master (
        input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_zero, alu_positive, alu_negative,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_in1, alu_in2, alu_op, alu_shift, nzp, done, illegal
    );
    modport slave (
        output instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_zero, alu_positive, alu_negative,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_in1, alu_in2, alu_op, alu_shift, nzp, done, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational decode of an LC-3b operate instruction into ALU controls
module alu_decode
    import alu_sequencer_pkg::*;
(
    input  logic [15:0] instr_i,
    output alu_op_e     alu_op_o,
    output logic [3:0]  alu_shift_o,
    output logic        imm_sel_o,
    output logic [15:0] imm16_o,
    output logic [2:0]  sr1_o,
    output logic [2:0]  sr2_o,
    output logic [2:0]  dr_o,
    output logic        illegal_o
);
    logic [3:0] opc;
    logic [1:0] sh;
    logic       is_shf;
    assign opc         = instr_i[15:12];
    assign sh          = instr_i[5:4];
    assign is_shf      = opc == OPC_SHF;
    assign dr_o        = instr_i[11:9];
    assign sr1_o       = instr_i[8:6];
    assign sr2_o       = instr_i[2:0];
    // SHF has no second operand; forcing the immediate path keeps alu_in2 at zero
    assign imm_sel_o   = is_shf | instr_i[5];
    assign imm16_o     = is_shf ? '0 : {{11{instr_i[4]}}, instr_i[4:0]};
    assign alu_shift_o = is_shf ? instr_i[3:0] : '0;
    assign illegal_o   = !(opc inside {OPC_ADD, OPC_AND, OPC_XOR, OPC_SHF}) || (is_shf && sh == 2'b10);
    always_comb
        alu_op_o = illegal_o          ? ALU_ZERO :
                   opc == OPC_ADD     ? ALU_ADD  :
                   opc == OPC_AND     ? ALU_AND  :
                   opc == OPC_XOR     ? ((instr_i[5] && &instr_i[4:0]) ? ALU_NOT : ALU_XOR) :
                   sh == 2'b00        ? ALU_LSHF :
                   sh == 2'b01        ? ALU_RSHFL : ALU_RSHFA;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/WB issue and writeback controller around the LC-3b ALU
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.master  bus
);
    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  flag_q, flag_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        wb_q, wb_d;
    logic        illegal_q, illegal_d;
    alu_op_e     dec_op;
    logic [3:0]  dec_shift;
    logic        dec_imm_sel;
    logic [15:0] dec_imm;
    logic [2:0]  dec_sr1, dec_sr2, dec_dr;
    logic        dec_ill;
    logic        exec;
    alu_decode u_dec (
        .instr_i     (instr_q),
        .alu_op_o    (dec_op),
        .alu_shift_o (dec_shift),
        .imm_sel_o   (dec_imm_sel),
        .imm16_o     (dec_imm),
        .sr1_o       (dec_sr1),
        .sr2_o       (dec_sr2),
        .dr_o        (dec_dr),
        .illegal_o   (dec_ill)
    );
    assign exec            = state_q == S_EXEC;
    assign bus.instr_ready = rst_n && state_q == S_IDLE;
    assign bus.rf_raddr1   = dec_sr1;
    assign bus.rf_raddr2   = dec_sr2;
    assign bus.alu_op      = exec ? dec_op : ALU_ZERO;
    assign bus.alu_in1     = exec ? bus.rf_rdata1 : '0;
    assign bus.alu_in2     = exec ? (dec_imm_sel ? dec_imm : bus.rf_rdata2) : '0;
    assign bus.alu_shift   = exec ? dec_shift : '0;
    assign bus.rf_we       = wb_q;
    assign bus.done        = wb_q;
    assign bus.rf_waddr    = dec_dr;
    assign bus.rf_wdata    = result_q;
    assign bus.nzp         = nzp_q;
    assign bus.illegal     = illegal_q;
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        result_d  = result_q;
        flag_d    = flag_q;
        nzp_d     = nzp_q;
        wb_d      = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: if (bus.instr_valid) begin
                instr_d = bus.instr;
                state_d = S_EXEC;
            end
            S_EXEC: if (dec_ill) begin
                illegal_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                result_d = bus.alu_out;
                flag_d   = {bus.alu_negative, bus.alu_zero, bus.alu_positive & ~bus.alu_zero};
                wb_d     = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                nzp_d   = flag_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            flag_q    <= NZP_RST;
            nzp_q     <= NZP_RST;
            wb_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            flag_q    <= flag_d;
            nzp_q     <= nzp_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
